alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle operand/control sequencer that drives the combinational ALU. It owns the architectural register file. It accepts one decoded operation at a time over a valid/ready request channel. It reads source operands, drives busA/busB/op/funct3/funct7 to the ALU, captures busC, writes the result back, and reports completion over a valid/ready response channel.

Parameters:
XLEN, 32, datapath width (ALU buses, registers, immediate)
NREGS, 32, register count; index width is clog2(NREGS)=5

Ports:
clk  in  1  single system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  7  ALU op code
req_funct3  in  3  passed to ALU unchanged
req_funct7  in  7  passed to ALU unchanged
req_rs1  in  5  source register A index
req_rs2  in  5  source register B index
req_rd  in  5  destination register index
req_imm  in  XLEN  immediate operand
req_use_imm  in  1  1: busB = req_imm; 0: busB = reg[rs2]
alu_busA  out  XLEN  ALU operand A (registered)
alu_busB  out  XLEN  ALU operand B (registered)
alu_op  out  7  ALU op (registered)
alu_funct3  out  3  registered
alu_funct7  out  7  registered
alu_busC  in  XLEN  ALU result (combinational from alu_* outputs)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  XLEN  result value
rsp_rd  out  5  destination index of result
rsp_err  out  1  op code not supported; no writeback performed

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. req_ready=0 during the reset cycle, 1 on the first cycle after. rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, alu_busA=alu_busB=0, alu_op=0, alu_funct3=0, alu_funct7=0. All NREGS registers cleared to 0. Reset mid-operation aborts the operation: no writeback, no response.
- reg[0] is hardwired zero: it reads 0 and writes to it are discarded.
- Supported ALU op codes: 0x00 zero, 0x01 one, 0x02 A+B, 0x03 A-B, 0x04 A+1, 0x05 A-1, 0x08 pass A, 0x09 pass B. All other codes are illegal.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/funct3/funct7/rs1/rs2/rd/imm/use_imm and go to READ.
- READ: req_ready=0. Load alu_busA=reg[rs1]; load alu_busB=use_imm?imm:reg[rs2]; load alu_op/funct3/funct7. Go to EXEC.
- EXEC: alu_* outputs are stable. At the end of the cycle:
  - legal op: capture alu_busC into rsp_data, set rsp_err=0, and write reg[rd]=alu_busC if rd!=0.
  - illegal op: rsp_data=0, rsp_err=1, no write.
  - In both cases rsp_rd=rd. Go to WB.
- WB: rsp_valid=1. rsp_data/rsp_rd/rsp_err hold stable until handshake. On rsp_ready=1, go to IDLE with rsp_valid=0 the next cycle. The register write occurs exactly once, on EXEC->WB, regardless of how long the response stalls.
- Latency: request accepted at edge N, rsp_valid high from cycle N+3. Minimum 4 cycles per operation with rsp_ready tied high.
- alu_* outputs keep their last values outside READ/EXEC; they are not re-zeroed between operations.
- Hazards: source reads in READ see all completed writebacks, because only one operation is in flight.
- Arithmetic wraps modulo 2^XLEN (ALU behaviour); no overflow flag.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
1. Reset, then reg writes via op 0x01 to rd=1, then op 0x02 rs1=1,rs2=1,rd=2 -> rsp_data=1 then 2; reg[2]=2; each rsp_valid exactly 3 cycles after acceptance.
2. Op 0x03 with use_imm=1, imm=5, rs1=0, rd=3 -> rsp_data=0xFFFFFFFB (wrap); second op 0x08 rs1=3 returns 0xFFFFFFFB.
3. Op 0x05 to rd=0 with rs1=0 -> rsp_data=0xFFFFFFFF, rsp_rd=0; follow-up pass-A of rs1=0 returns 0.
4. Illegal op 0x07 to rd=4 -> rsp_err=1, rsp_data=0; reg[4] unchanged (pass-A returns prior value).
5. Hold rsp_ready=0 for 10 cycles in WB -> rsp_* stable, req_ready=0, reg[rd] written once; release -> IDLE next cycle, new request accepted.
6. Assert rst during EXEC of op 0x04 rd=5 -> no response, rsp_valid=0, all regs 0, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle operand/control sequencer for a combinational ALU.
// Owns the register file, reads sources, drives the ALU, writes back the result and reports completion.
module alu_sequencer #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_op,
  input  logic [2:0]      req_funct3,
  input  logic [6:0]      req_funct7,
  input  logic [IW-1:0]   req_rs1,
  input  logic [IW-1:0]   req_rs2,
  input  logic [IW-1:0]   req_rd,
  input  logic [XLEN-1:0] req_imm,
  input  logic            req_use_imm,
  output logic [XLEN-1:0] alu_busA,
  output logic [XLEN-1:0] alu_busB,
  output logic [6:0]      alu_op,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_busC,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [IW-1:0]   rsp_rd,
  output logic            rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]      state;
  logic [6:0]      op_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [IW-1:0]   rs1_q;
  logic [IW-1:0]   rs2_q;
  logic [IW-1:0]   rd_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h08, 7'h09: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // Register 0 reads as zero regardless of storage contents.
  always_comb begin
    src_a = (rs1_q == '0) ? '0 : regs[rs1_q];
    if (use_imm_q) begin
      src_b = imm_q;
    end else begin
      src_b = (rs2_q == '0) ? '0 : regs[rs2_q];
    end
  end

  assign req_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      alu_busA   <= '0;
      alu_busB   <= '0;
      alu_op     <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      rsp_err    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            funct3_q  <= req_funct3;
            funct7_q  <= req_funct7;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            rd_q      <= req_rd;
            imm_q     <= req_imm;
            use_imm_q <= req_use_imm;
            state     <= S_READ;
          end
        end
        S_READ: begin
          alu_busA   <= src_a;
          alu_busB   <= src_b;
          alu_op     <= op_q;
          alu_funct3 <= funct3_q;
          alu_funct7 <= funct7_q;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          // The only writeback point, so a stalled response cannot repeat the write.
          rsp_rd    <= rd_q;
          rsp_valid <= 1'b1;
          if (op_legal(op_q)) begin
            rsp_data <= alu_busC;
            rsp_err  <= 1'b0;
            if (rd_q != '0) begin
              regs[rd_q] <= alu_busC;
            end
          end else begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
          state <= S_WB;
        end
        S_WB: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
